box_cmd_rx: RTL and testbench

Receives the UDP RX byte stream carrying draw-box commands from the host, validates framing and checksum, and presents a tear-free box list to the box-drawing path. It sits between the UDP packet engine's RX side and the box-coordinate parser, replacing the raw byte-capture buffer. Validated boxes are triple-buffered (staging, pending, active) and committed only on a frame-sync pulse, so on-screen boxes never change mid-frame.

---
 rtl/box_cmd_pkg.sv | 22 ++
 rtl/box_cmd_rx_if.sv | 10 +
 rtl/box_cmd_parse_fsm.sv | 182 ++++++++++++++++++
 rtl/box_cmd_rx.sv | 100 ++++++++++
 tb/tb_box_cmd_rx.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_cmd_pkg.sv
// Shared types and constants for the draw-box command receiver.
package box_cmd_pkg;

    localparam int         BOX_BYTES_DEFAULT = 6;   // matches DRAW_BOX_DATA_BYTE
    localparam logic [7:0] MAGIC_DEFAULT     = 8'hA5;

    localparam logic [1:0] ERR_MAGIC = 2'd0;
    localparam logic [1:0] ERR_CNT   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEQ  = 3'd1,
        ST_CNT  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CSUM = 3'd4,
        ST_TAIL = 3'd5,
        ST_DROP = 3'd6
    } box_state_e;

endpackage

// File: rtl/box_cmd_rx_if.sv
// RX byte stream from the UDP packet engine into the box command receiver.
interface box_cmd_rx_if;
    // Valid-only stream: no back-pressure, a byte is taken on every clock with
    // rx_valid high, and one packet is one unbroken run of rx_valid.
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output rx_valid, rx_data);
    modport slave  (input  rx_valid, rx_data);
endinterface

// File: rtl/box_cmd_parse_fsm.sv
// Packet framing FSM: checks magic/count/checksum/length and fills the staging buffer.
module box_cmd_parse_fsm
    import box_cmd_pkg::*;
#(
    parameter int         BOX_NUM   = 1,
    parameter int         BOX_BYTES = BOX_BYTES_DEFAULT,
    parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
    localparam int        STG_W     = BOX_NUM * BOX_BYTES * 8,
    localparam int        CNT_W     = $clog2(BOX_NUM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    box_cmd_rx_if.slave       rx,
    output logic [STG_W-1:0]  stage_data,
    output logic [CNT_W-1:0]  stage_cnt,
    output logic [7:0]        stage_seq,
    output logic              pkt_good,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output box_state_e        state_dbg
);

    localparam int IDX_W = $clog2(BOX_NUM * BOX_BYTES + 1);

    box_state_e        state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        seq_q, seq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic              err_q;
    logic [1:0]        code_q, code_d;
    logic              err_fire;
    logic [1:0]        err_sel;
    logic              vld;
    logic [7:0]        dat;
    logic              cnt_over;

    assign vld      = rx.rx_valid;
    assign dat      = rx.rx_data;
    assign cnt_over = 32'(dat) > BOX_NUM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            stg_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            stg_q   <= stg_d;
            err_q   <= err_fire;
            code_q  <= code_d;
        end
    end

    // A gap inside SEQ..CSUM is a truncation and goes straight back to IDLE.
    always_comb begin
        state_d  = state_q;
        err_fire = 1'b0;
        err_sel  = ERR_MAGIC;
        pkt_good = 1'b0;
        case (state_q)
            ST_IDLE: if (vld) begin
                if (dat == MAGIC) begin
                    state_d = ST_SEQ;
                end else begin
                    err_fire = 1'b1;
                    err_sel  = ERR_MAGIC;
                    state_d  = ST_DROP;
                end
            end
            ST_SEQ: begin
                if (!vld) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_LEN;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!vld) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_LEN;
                    state_d  = ST_IDLE;
                end else if (cnt_over) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_CNT;
                    state_d  = ST_DROP;
                end else begin
                    state_d = (dat == 8'd0) ? ST_CSUM : ST_PAY;
                end
            end
            ST_PAY: begin
                if (!vld) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_LEN;
                    state_d  = ST_IDLE;
                end else if (idx_q == last_q) begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (!vld) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_LEN;
                    state_d  = ST_IDLE;
                end else if (dat != acc_q) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_CSUM;
                    state_d  = ST_DROP;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (vld) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_LEN;
                    state_d  = ST_DROP;
                end else begin
                    pkt_good = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: if (!vld) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        seq_d  = seq_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        last_d = last_q;
        stg_d  = stg_q;
        code_d = err_fire ? err_sel : code_q;
        case (state_q)
            ST_IDLE: begin
                acc_d = dat;
                idx_d = '0;
            end
            ST_SEQ: if (vld) begin
                seq_d = dat;
                acc_d = acc_q ^ dat;
            end
            ST_CNT: if (vld && !cnt_over) begin
                cnt_d  = CNT_W'(dat);
                last_d = IDX_W'(32'(dat) * BOX_BYTES - 1);
                stg_d  = '0;
                acc_d  = acc_q ^ dat;
            end
            ST_PAY: if (vld) begin
                stg_d[8*idx_q +: 8] = dat;
                idx_d = idx_q + IDX_W'(1);
                acc_d = acc_q ^ dat;
            end
            default: ;
        endcase
    end

    assign stage_data = stg_q;
    assign stage_cnt  = cnt_q;
    assign stage_seq  = seq_q;
    assign pkt_err    = err_q;
    assign err_code   = code_q;
    assign state_dbg  = state_q;

endmodule

// File: rtl/box_cmd_rx.sv
// Box command receiver: parses RX packets, holds pending/active box lists,
// and commits pending to active only on frame_sync so boxes never tear mid-frame.
module box_cmd_rx
    import box_cmd_pkg::*;
#(
    parameter int         BOX_NUM   = 1,
    parameter int         BOX_BYTES = BOX_BYTES_DEFAULT,
    parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
    localparam int        BOX_W     = BOX_NUM * BOX_BYTES * 8,
    localparam int        CNT_W     = $clog2(BOX_NUM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    box_cmd_rx_if.slave       rx,
    input  logic              frame_sync,
    output logic [BOX_W-1:0]  boxes,
    output logic [CNT_W-1:0]  box_cnt,
    output logic [7:0]        seq,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic              commit,
    output box_state_e        state_dbg
);

    logic [BOX_W-1:0]  stg_data;
    logic [CNT_W-1:0]  stg_cnt;
    logic [7:0]        stg_seq;
    logic              pkt_good;

    logic [BOX_W-1:0]  pend_data_q, pend_data_d;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic [7:0]        pend_seq_q, pend_seq_d;
    logic              pend_flag_q, pend_flag_d;
    logic [BOX_W-1:0]  act_data_q, act_data_d;
    logic [CNT_W-1:0]  act_cnt_q, act_cnt_d;
    logic [7:0]        act_seq_q, act_seq_d;
    logic              pkt_ok_q, commit_q, commit_d;

    box_cmd_parse_fsm #(
        .BOX_NUM   (BOX_NUM),
        .BOX_BYTES (BOX_BYTES),
        .MAGIC     (MAGIC)
    ) u_parse (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .stage_data (stg_data),
        .stage_cnt  (stg_cnt),
        .stage_seq  (stg_seq),
        .pkt_good   (pkt_good),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .state_dbg  (state_dbg)
    );

    // The pending load happens in the pkt_ok cycle; a frame_sync in that same
    // cycle still commits the older pending contents, and the new packet waits.
    always_comb begin
        commit_d    = frame_sync & pend_flag_q;
        act_data_d  = commit_d ? pend_data_q : act_data_q;
        act_cnt_d   = commit_d ? pend_cnt_q  : act_cnt_q;
        act_seq_d   = commit_d ? pend_seq_q  : act_seq_q;
        pend_data_d = pkt_ok_q ? stg_data : pend_data_q;
        pend_cnt_d  = pkt_ok_q ? stg_cnt  : pend_cnt_q;
        pend_seq_d  = pkt_ok_q ? stg_seq  : pend_seq_q;
        pend_flag_d = pkt_ok_q ? 1'b1 : (commit_d ? 1'b0 : pend_flag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data_q <= '0;
            pend_cnt_q  <= '0;
            pend_seq_q  <= '0;
            pend_flag_q <= 1'b0;
            act_data_q  <= '0;
            act_cnt_q   <= '0;
            act_seq_q   <= '0;
            pkt_ok_q    <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            pend_data_q <= pend_data_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_seq_q  <= pend_seq_d;
            pend_flag_q <= pend_flag_d;
            act_data_q  <= act_data_d;
            act_cnt_q   <= act_cnt_d;
            act_seq_q   <= act_seq_d;
            pkt_ok_q    <= pkt_good;
            commit_q    <= commit_d;
        end
    end

    assign boxes   = act_data_q;
    assign box_cnt = act_cnt_q;
    assign seq     = act_seq_q;
    assign pkt_ok  = pkt_ok_q;
    assign commit  = commit_q;

endmodule

// File: tb/tb_box_cmd_rx.sv
// Directed bench for box_cmd_rx with BOX_NUM=2, BOX_BYTES=6.
module tb_box_cmd_rx;
    import box_cmd_pkg::*;

    localparam int BOX_W = 96;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_sync = 1'b0;
    logic [BOX_W-1:0] boxes;
    logic [CNT_W-1:0] box_cnt;
    logic [7:0]       seq;
    logic             pkt_ok, pkt_err, commit;
    logic [1:0]       err_code;
    box_state_e       state_dbg;

    box_cmd_rx_if rx ();

    box_cmd_rx #(.BOX_NUM(2), .BOX_BYTES(6), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .frame_sync (frame_sync),
        .boxes      (boxes),
        .box_cnt    (box_cnt),
        .seq        (seq),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .commit     (commit),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ok_cnt  = 0;
    int err_cnt = 0;
    int com_cnt = 0;
    logic [7:0] pkt[$];

    always @(negedge clk) begin
        if (pkt_ok === 1'b1)  ok_cnt++;
        if (pkt_err === 1'b1) err_cnt++;
        if (commit === 1'b1)  com_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'h00;
        foreach (pkt[i]) x ^= pkt[i];
        return x;
    endfunction

    task automatic build(input logic [7:0] s, input int n, input logic [7:0] base);
        pkt = {8'hA5, s, 8'(n)};
        for (int i = 0; i < n * 6; i++) pkt.push_back(base + 8'(i));
        pkt.push_back(xsum());
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) begin
            rx.rx_valid = 1'b1;
            rx.rx_data  = pkt[i];
            tick();
        end
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
    endtask

    task automatic fs_pulse();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_tests++; if (boxes !== '0) begin n_fail++; $display("FAIL reset_boxes: got %h exp 0", boxes); end
        n_tests++; if (box_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_box_cnt: got %0d exp 0", box_cnt); end
        n_tests++; if (seq !== 8'h00) begin n_fail++; $display("FAIL reset_seq: got %h exp 00", seq); end
        n_tests++; if ({pkt_ok, pkt_err, commit} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b exp 000", {pkt_ok, pkt_err, commit}); end
        n_tests++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d exp 0", err_code); end
        n_tests++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_good();
        pkt = {8'hA5, 8'h07, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        pkt.push_back(8'hD3);
        tick();
        send_pkt();
        tick();
        n_tests++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL good_pkt_ok: got %b exp 1", pkt_ok); end
        n_tests++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL good_no_err: got %b exp 0", pkt_err); end
        tick();
        n_tests++; if (pkt_ok !== 1'b0) begin n_fail++; $display("FAIL good_pkt_ok_single: got %b exp 0", pkt_ok); end
        n_tests++; if (seq !== 8'h00) begin n_fail++; $display("FAIL good_no_early_commit: got %h exp 00", seq); end
        tick();
        fs_pulse();
        n_tests++; if (commit !== 1'b1) begin n_fail++; $display("FAIL good_commit: got %b exp 1", commit); end
        n_tests++; if (boxes !== {48'h0, 48'h605040302010}) begin n_fail++; $display("FAIL good_boxes: got %h exp %h", boxes, {48'h0, 48'h605040302010}); end
        n_tests++; if (box_cnt !== 2'd1) begin n_fail++; $display("FAIL good_box_cnt: got %0d exp 1", box_cnt); end
        n_tests++; if (seq !== 8'h07) begin n_fail++; $display("FAIL good_seq: got %h exp 07", seq); end
        tick();
        n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL good_commit_single: got %b exp 0", commit); end
        fs_pulse();
        n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL idle_fs_no_commit: got %b exp 0", commit); end
    endtask

    task automatic test_bad_csum();
        int e0, o0;
        e0 = err_cnt; o0 = ok_cnt;
        pkt = {8'hA5, 8'h08, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        pkt.push_back(xsum() ^ 8'h01);
        tick();
        send_pkt();
        n_tests++; if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL csum_pkt_err: got %b exp 1", pkt_err); end
        n_tests++; if (err_code !== ERR_CSUM) begin n_fail++; $display("FAIL csum_err_code: got %0d exp 2", err_code); end
        tick();
        n_tests++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL csum_err_single: got %b exp 0", pkt_err); end
        tick(); tick();
        fs_pulse();
        n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL csum_no_commit: got %b exp 0", commit); end
        n_tests++; if (seq !== 8'h07 || boxes !== {48'h0, 48'h605040302010}) begin n_fail++; $display("FAIL csum_active_kept: got seq %h boxes %h exp 07 / 605040302010", seq, boxes); end
        tick();
        n_tests++; if (ok_cnt !== o0 || err_cnt !== e0 + 1) begin n_fail++; $display("FAIL csum_pulse_counts: got ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, o0, e0 + 1); end
    endtask

    task automatic test_bad_cnt();
        int e0;
        e0 = err_cnt;
        build(8'h09, 3, 8'h40);
        tick();
        send_pkt();
        tick();
        n_tests++; if (err_code !== ERR_CNT) begin n_fail++; $display("FAIL cnt_err_code: got %0d exp 1", err_code); end
        n_tests++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL cnt_err_once: got %0d exp %0d", err_cnt, e0 + 1); end
        build(8'h0A, 2, 8'h01);
        tick();
        send_pkt();
        tick();
        n_tests++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL cnt_next_pkt_ok: got %b exp 1", pkt_ok); end
        tick(); tick();
        fs_pulse();
        n_tests++; if (seq !== 8'h0A) begin n_fail++; $display("FAIL cnt_next_seq: got %h exp 0A", seq); end
        n_tests++; if (box_cnt !== 2'd2) begin n_fail++; $display("FAIL cnt_next_box_cnt: got %0d exp 2", box_cnt); end
        n_tests++; if (boxes !== 96'h0C0B0A090807_060504030201) begin n_fail++; $display("FAIL cnt_next_boxes: got %h exp 0C0B0A090807060504030201", boxes); end
    endtask

    task automatic test_len();
        int e0, o0;
        e0 = err_cnt; o0 = ok_cnt;
        pkt = {8'hA5, 8'h0B, 8'h01, 8'h11, 8'h22};
        tick();
        send_pkt();
        tick();
        n_tests++; if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL trunc_pkt_err: got %b exp 1", pkt_err); end
        n_tests++; if (err_code !== ERR_LEN) begin n_fail++; $display("FAIL trunc_err_code: got %0d exp 3", err_code); end
        tick();
        pkt = {8'h5A, 8'h01, 8'h02};
        send_pkt();
        tick();
        n_tests++; if (err_code !== ERR_MAGIC) begin n_fail++; $display("FAIL magic_err_code: got %0d exp 0", err_code); end
        tick();
        build(8'h0E, 1, 8'h71);
        pkt.push_back(8'h00);
        send_pkt();
        n_tests++; if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL long_pkt_err: got %b exp 1", pkt_err); end
        n_tests++; if (err_code !== ERR_LEN) begin n_fail++; $display("FAIL long_err_code: got %0d exp 3", err_code); end
        tick(); tick();
        n_tests++; if (ok_cnt !== o0 || err_cnt !== e0 + 3) begin n_fail++; $display("FAIL len_pulse_counts: got ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, o0, e0 + 3); end
        fs_pulse();
        n_tests++; if (commit !== 1'b0 || seq !== 8'h0A) begin n_fail++; $display("FAIL len_no_commit: got commit %b seq %h exp 0 / 0A", commit, seq); end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = com_cnt;
        build(8'h01, 1, 8'h11);
        tick();
        send_pkt();
        tick(); tick();
        build(8'h02, 1, 8'h21);
        send_pkt();
        tick(); tick(); tick();
        fs_pulse();
        n_tests++; if (commit !== 1'b1 || seq !== 8'h02) begin n_fail++; $display("FAIL b2b_last_wins: got commit %b seq %h exp 1 / 02", commit, seq); end
        n_tests++; if (boxes !== {48'h0, 48'h262524232221} || box_cnt !== 2'd1) begin n_fail++; $display("FAIL b2b_boxes: got %h cnt %0d exp 262524232221 / 1", boxes, box_cnt); end
        tick();
        fs_pulse();
        tick();
        n_tests++; if (com_cnt !== c0 + 1) begin n_fail++; $display("FAIL b2b_single_commit: got %0d exp %0d", com_cnt, c0 + 1); end
        build(8'h03, 1, 8'h31);
        send_pkt();
        tick(); tick(); tick();
        build(8'h04, 1, 8'h41);
        send_pkt();
        tick();
        n_tests++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL coinc_pkt_ok: got %b exp 1", pkt_ok); end
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        n_tests++; if (commit !== 1'b1 || seq !== 8'h03) begin n_fail++; $display("FAIL coinc_old_commit: got commit %b seq %h exp 1 / 03", commit, seq); end
        n_tests++; if (boxes !== {48'h0, 48'h363534333231}) begin n_fail++; $display("FAIL coinc_old_boxes: got %h exp 363534333231", boxes); end
        tick(); tick();
        fs_pulse();
        n_tests++; if (commit !== 1'b1 || seq !== 8'h04) begin n_fail++; $display("FAIL coinc_new_commit: got commit %b seq %h exp 1 / 04", commit, seq); end
        n_tests++; if (boxes !== {48'h0, 48'h464544434241}) begin n_fail++; $display("FAIL coinc_new_boxes: got %h exp 464544434241", boxes); end
    endtask

    task automatic test_reset_mid();
        int e0;
        pkt = {8'hA5, 8'h0C, 8'h01, 8'h51, 8'h52};
        tick();
        send_pkt();
        n_tests++; if (state_dbg !== ST_PAY) begin n_fail++; $display("FAIL rmid_in_pay: got %0d exp %0d", state_dbg, ST_PAY); end
        rx.rx_valid = 1'b1;
        rx.rx_data  = 8'h53;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (boxes !== '0 || box_cnt !== 2'd0 || seq !== 8'h00) begin n_fail++; $display("FAIL rmid_outputs: got boxes %h cnt %0d seq %h exp 0", boxes, box_cnt, seq); end
        n_tests++; if ({pkt_ok, pkt_err, commit, err_code} !== 5'b0) begin n_fail++; $display("FAIL rmid_flags: got %b exp 00000", {pkt_ok, pkt_err, commit, err_code}); end
        n_tests++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d exp %0d", state_dbg, ST_IDLE); end
        e0 = err_cnt;
        pkt = {8'h54, 8'h55, 8'h56, 8'h5A};
        send_pkt();
        tick(); tick();
        n_tests++; if (err_cnt !== e0 + 1 || err_code !== ERR_MAGIC) begin n_fail++; $display("FAIL rmid_tail_drop: got errs %0d code %0d exp %0d / 0", err_cnt - e0, err_code, 1); end
        build(8'h0D, 1, 8'h61);
        send_pkt();
        tick(); tick(); tick();
        fs_pulse();
        n_tests++; if (commit !== 1'b1 || seq !== 8'h0D || box_cnt !== 2'd1) begin n_fail++; $display("FAIL rmid_next_commit: got commit %b seq %h cnt %0d exp 1 / 0D / 1", commit, seq, box_cnt); end
        n_tests++; if (boxes !== {48'h0, 48'h666564636261}) begin n_fail++; $display("FAIL rmid_next_boxes: got %h exp 666564636261", boxes); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_bad_cnt();
        test_len();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
